// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared state codes and helpers for the game controller and menu_mux
package game_pkg;

    typedef enum logic [2:0] {
        S_START     = 3'd0,
        S_COUNTDOWN = 3'd1,
        S_GAME      = 3'd2,
        S_PAUSE     = 3'd3,
        S_DYING     = 3'd4,
        S_GAMEOVER  = 3'd5
    } state_t;

    localparam logic [2:0] ST_START     = 3'd0;
    localparam logic [2:0] ST_COUNTDOWN = 3'd1;
    localparam logic [2:0] ST_GAME      = 3'd2;
    localparam logic [2:0] ST_PAUSE     = 3'd3;
    localparam logic [2:0] ST_DYING     = 3'd4;
    localparam logic [2:0] ST_GAMEOVER  = 3'd5;

    // Bits needed to count 0..limit-1, never less than one.
    function automatic int unsigned cnt_width(input int unsigned limit);
        return (limit < 2) ? 1 : $clog2(limit);
    endfunction

endpackage

// File: rtl/cycle_timer.sv
// rtl/cycle_timer.sv - wrapping 0..LIMIT-1 cycle counter with clear, enable and terminal-count pulse
module cycle_timer #(
    parameter int unsigned LIMIT = 4,
    parameter int unsigned W     = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        tc_o  = 1'b0;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            if (cnt_q == LAST) begin
                cnt_d = '0;
                tc_o  = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/game_ctrl.sv
// rtl/game_ctrl.sv - game flow FSM: start, countdown, play, pause, death freeze and game over
module game_ctrl
    import game_pkg::*;
#(
    parameter int unsigned LIVES           = 3,
    parameter int unsigned COUNTDOWN_TICKS = 3,
    parameter int unsigned TICK_CYCLES     = 65_000_000,
    parameter int unsigned DEATH_HOLD      = 32_500_000,
    parameter int unsigned INVULN_CYCLES   = 130_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       mouse_left,
    input  logic       mouse_right,
    input  logic       collision,
    output logic [2:0] state,
    output logic [3:0] lives,
    output logic [3:0] countdown,
    output logic       run,
    output logic       invuln,
    output logic       life_lost,
    output logic       game_over
);

    localparam int unsigned INV_LIMIT = (INVULN_CYCLES == 0) ? 1 : INVULN_CYCLES;

    logic [2:0] state_q, state_d;
    logic [3:0] lives_q, lives_d;
    logic [3:0] cd_q, cd_d;
    logic       run_q, inv_q, inv_d, ll_q, ll_d, go_q, go_d;
    logic       ml_q, mr_q;
    logic       click_l, click_r;
    logic       tick_tc, hold_tc, inv_tc;

    assign click_l = mouse_left  & ~ml_q;
    assign click_r = mouse_right & ~mr_q;

    cycle_timer #(.LIMIT(TICK_CYCLES), .W(cnt_width(TICK_CYCLES))) u_tick (
        .clk(clk), .rst_n(rst_n),
        .clr_i(state_q != ST_COUNTDOWN), .en_i(state_q == ST_COUNTDOWN),
        .tc_o(tick_tc)
    );

    cycle_timer #(.LIMIT(DEATH_HOLD), .W(cnt_width(DEATH_HOLD))) u_hold (
        .clk(clk), .rst_n(rst_n),
        .clr_i(state_q != ST_DYING), .en_i(state_q == ST_DYING),
        .tc_o(hold_tc)
    );

    // Immunity window is counted up from zero while inv_q is set; tc ends it.
    cycle_timer #(.LIMIT(INV_LIMIT), .W(cnt_width(INV_LIMIT))) u_inv (
        .clk(clk), .rst_n(rst_n),
        .clr_i(!inv_q), .en_i(inv_q && (state_q == ST_GAME)),
        .tc_o(inv_tc)
    );

    always_comb begin
        state_d = state_q;
        lives_d = lives_q;
        cd_d    = cd_q;
        inv_d   = inv_q;
        ll_d    = 1'b0;
        go_d    = 1'b0;
        case (state_q)
            ST_START: begin
                if (click_l) begin
                    state_d = ST_COUNTDOWN;
                    lives_d = 4'(LIVES);
                    cd_d    = 4'(COUNTDOWN_TICKS);
                    inv_d   = 1'b0;
                end
            end
            ST_COUNTDOWN: begin
                if (cd_q == 4'd0) begin
                    state_d = ST_GAME;
                end else if (tick_tc) begin
                    cd_d = cd_q - 4'd1;
                    if (cd_q == 4'd1) state_d = ST_GAME;
                end
            end
            ST_GAME: begin
                if (inv_tc) inv_d = 1'b0;
                if (collision && !inv_q) begin
                    state_d = ST_DYING;
                    lives_d = (lives_q == 4'd0) ? 4'd0 : lives_q - 4'd1;
                    ll_d    = 1'b1;
                end else if (click_r) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (click_r) state_d = ST_GAME;
            end
            ST_DYING: begin
                if (hold_tc) begin
                    if (lives_q == 4'd0) begin
                        state_d = ST_GAMEOVER;
                        go_d    = 1'b1;
                    end else begin
                        state_d = ST_COUNTDOWN;
                        cd_d    = 4'(COUNTDOWN_TICKS);
                        inv_d   = (INVULN_CYCLES != 0);
                    end
                end
            end
            ST_GAMEOVER: begin
                if (click_l) state_d = ST_START;
            end
            default: state_d = ST_START;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_START;
            lives_q <= 4'd0;
            cd_q    <= 4'd0;
            run_q   <= 1'b0;
            inv_q   <= 1'b0;
            ll_q    <= 1'b0;
            go_q    <= 1'b0;
            ml_q    <= 1'b0;
            mr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            lives_q <= lives_d;
            cd_q    <= cd_d;
            run_q   <= (state_d == ST_GAME);
            inv_q   <= inv_d;
            ll_q    <= ll_d;
            go_q    <= go_d;
            ml_q    <= mouse_left;
            mr_q    <= mouse_right;
        end
    end

    assign state     = state_q;
    assign lives     = lives_q;
    assign countdown = cd_q;
    assign run       = run_q;
    assign invuln    = inv_q;
    assign life_lost = ll_q;
    assign game_over = go_q;

endmodule

// File: tb/tb_game_ctrl.sv
// tb/tb_game_ctrl.sv - scoreboard bench for game_ctrl with short timing parameters
module tb_game_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ml = 1'b0, mr = 1'b0, col = 1'b0;
    logic [2:0] state;
    logic [3:0] lives, countdown;
    logic       run, invuln, life_lost, game_over;
    logic [14:0] obs;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       tag;
        logic [14:0] exp;
    } sb_t;

    sb_t sb[$];
    sb_t head;

    game_ctrl #(
        .LIVES(2), .COUNTDOWN_TICKS(2), .TICK_CYCLES(4), .DEATH_HOLD(3), .INVULN_CYCLES(5)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .mouse_left(ml), .mouse_right(mr), .collision(col),
        .state(state), .lives(lives), .countdown(countdown),
        .run(run), .invuln(invuln), .life_lost(life_lost), .game_over(game_over)
    );

    always #5 clk = ~clk;

    assign obs = {state, lives, countdown, run, invuln, life_lost, game_over};

    function automatic logic [14:0] v(input int st, input int lv, input int cd,
                                      input int r, input int i, input int ll, input int go);
        return {3'(st), 4'(lv), 4'(cd), 1'(r), 1'(i), 1'(ll), 1'(go)};
    endfunction

    task automatic check(input string tag, input logic [14:0] got, input logic [14:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got st=%0d lv=%0d cd=%0d run=%b inv=%b ll=%b go=%b, want st=%0d lv=%0d cd=%0d run=%b inv=%b ll=%b go=%b",
                     tag, got[14:12], got[11:8], got[7:4], got[3], got[2], got[1], got[0],
                     want[14:12], want[11:8], want[7:4], want[3], want[2], want[1], want[0]);
        end
    endtask

    task automatic tick(input logic l, input logic r, input logic c);
        ml  = l;
        mr  = r;
        col = c;
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n, input logic l, input logic r, input logic c);
        for (int i = 0; i < n; i++) tick(l, r, c);
    endtask

    task automatic expect_now(input string tag, input logic [14:0] e);
        sb.push_back('{tag, e});
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0) begin
            head = sb.pop_front();
            check(head.tag, obs, head.exp);
        end
    end

    initial begin
        #12;
        check("reset", obs, v(0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        tick(0, 0, 0);  expect_now("idle",       v(0, 0, 0, 0, 0, 0, 0));
        tick(1, 0, 0);  expect_now("cd_entry",   v(1, 2, 2, 0, 0, 0, 0));
        ticks(3, 0, 0, 0); expect_now("cd2_hold", v(1, 2, 2, 0, 0, 0, 0));
        tick(0, 0, 0);  expect_now("cd1",        v(1, 2, 1, 0, 0, 0, 0));
        ticks(3, 0, 0, 0);
        tick(0, 0, 0);  expect_now("game",       v(2, 2, 0, 1, 0, 0, 0));

        tick(0, 0, 1);  expect_now("die1",       v(4, 1, 0, 0, 0, 1, 0));
        ticks(2, 0, 0, 0); expect_now("hold",     v(4, 1, 0, 0, 0, 0, 0));
        tick(0, 0, 0);  expect_now("recount",    v(1, 1, 2, 0, 1, 0, 0));
        ticks(8, 0, 0, 0); expect_now("game_inv", v(2, 1, 0, 1, 1, 0, 0));

        tick(0, 0, 1);  expect_now("inv_ignore", v(2, 1, 0, 1, 1, 0, 0));
        tick(0, 1, 0);  expect_now("pause",      v(3, 1, 0, 0, 1, 0, 0));
        ticks(6, 0, 0, 1); expect_now("pause_hold", v(3, 1, 0, 0, 1, 0, 0));
        tick(0, 1, 0);  expect_now("resume",     v(2, 1, 0, 1, 1, 0, 0));
        ticks(2, 0, 0, 1); expect_now("inv_left", v(2, 1, 0, 1, 1, 0, 0));
        tick(0, 0, 1);  expect_now("inv_done",   v(2, 1, 0, 1, 0, 0, 0));

        tick(0, 1, 1);  expect_now("die2_prio",  v(4, 0, 0, 0, 0, 1, 0));
        ticks(2, 0, 0, 0); expect_now("hold2",    v(4, 0, 0, 0, 0, 0, 0));
        tick(0, 0, 0);  expect_now("gameover",   v(5, 0, 0, 0, 0, 0, 1));
        tick(0, 0, 0);  expect_now("go_pulse",   v(5, 0, 0, 0, 0, 0, 0));
        tick(0, 1, 0);  expect_now("r_ignored",  v(5, 0, 0, 0, 0, 0, 0));
        tick(1, 0, 0);  expect_now("to_start",   v(0, 0, 0, 0, 0, 0, 0));
        ticks(19, 1, 0, 0); expect_now("held",   v(0, 0, 0, 0, 0, 0, 0));
        tick(0, 0, 0);
        tick(1, 0, 0);  expect_now("restart",    v(1, 2, 2, 0, 0, 0, 0));
        ticks(2, 0, 0, 0);

        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst", obs, v(0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        rst_n = 1'b1;
        tick(0, 0, 0);  expect_now("post_rst",   v(0, 0, 0, 0, 0, 0, 0));
        tick(1, 0, 0);  expect_now("first_click", v(1, 2, 2, 0, 0, 0, 0));
        tick(0, 0, 0);

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/game_ctrl.md
GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 Parameter LIVES, default 3, lives granted per game (1..15).
REQ-002 Parameter COUNTDOWN_TICKS, default 3, countdown ticks before play (0..15).
REQ-003 Parameter TICK_CYCLES, default 65_000_000, clk cycles per countdown tick (>=1).
REQ-004 Parameter DEATH_HOLD, default 32_500_000, clk cycles the DYING freeze lasts (>=1).
REQ-005 Parameter INVULN_CYCLES, default 130_000_000, GAME cycles of collision immunity after a lost life (0 disables).
REQ-006 clk  in  1  system clock; the block uses one clock only.
REQ-007 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-008 mouse_left  in  1  level, clk-synchronous; rising edge = click_l.
REQ-009 mouse_right  in  1  level, clk-synchronous; rising edge = click_r.
REQ-010 collision  in  1  level, bird/pipe or bird/ground overlap.
REQ-011 state  out  3  current state code for menu_mux.
REQ-012 lives  out  4  remaining lives.
REQ-013 countdown  out  4  remaining countdown ticks.
REQ-014 run  out  1  high only in GAME; physics/scroll enable.
REQ-015 invuln  out  1  high while the immunity counter is non-zero.
REQ-016 life_lost  out  1  one-cycle pulse on entry to DYING.
REQ-017 game_over  out  1  one-cycle pulse on entry to GAMEOVER.

Function
REQ-018 States/codes: START=0, COUNTDOWN=1, GAME=2, PAUSE=3, DYING=4, GAMEOVER=5; codes 6-7 unreachable, recover to START next cycle.
REQ-019 click_l/click_r = input AND NOT previous registered input; one-cycle pulse per press, first click usable the cycle after reset release.
REQ-020 START: click_l -> COUNTDOWN; lives<=LIVES, countdown<=COUNTDOWN_TICKS, tick timer<=0, invuln counter<=0.
REQ-021 COUNTDOWN: tick timer counts 0..TICK_CYCLES-1; on wrap countdown decrements; when countdown reaches 0 -> GAME same edge; COUNTDOWN_TICKS=0 gives GAME one cycle after entry.
REQ-022 GAME: collision with invuln=0 -> DYING (priority); else click_r -> PAUSE; invuln counter decrements by 1 per GAME cycle, saturates at 0.
REQ-023 PAUSE: click_r -> GAME; all timers and counters hold; collision ignored.
REQ-024 DYING entry: lives decrements by 1 (saturating at 0), life_lost pulses, hold counter starts at 0.
REQ-025 DYING: after DEATH_HOLD cycles -> GAMEOVER if lives=0, else COUNTDOWN with countdown<=COUNTDOWN_TICKS, tick timer<=0, invuln counter<=INVULN_CYCLES.
REQ-026 GAMEOVER: click_l -> START; lives holds final value 0.
REQ-027 collision outside GAME, click_l outside START/GAMEOVER, click_r outside GAME/PAUSE: ignored.
REQ-028 All outputs registered; state change visible the cycle after the qualifying input edge.

Reset
REQ-029 rst_n low asynchronously forces state=START, lives=0, countdown=0, run=0, invuln=0, life_lost=0, game_over=0, all timers 0, edge registers 0.
REQ-030 Reset mid-game discards all progress; release resumes in START without spurious click.

Structure
REQ-031 state_t enum and state codes live in game_pkg, shared with menu_mux.
REQ-032 Cycle counters use one sub-module, cycle_timer (parametrised width, clear, enable, terminal-count pulse), instantiated for tick, hold and invuln.

Verification (bench params: LIVES=2, COUNTDOWN_TICKS=2, TICK_CYCLES=4, DEATH_HOLD=3, INVULN_CYCLES=5)
REQ-033 Reset then click_l -> state 1, lives=2, countdown 2->1->0 at 4-cycle steps, state 2 with run=1.
REQ-034 In GAME assert collision -> life_lost pulse, state 4, lives=1, after 3 cycles state 1, then GAME with invuln=1 for 5 GAME cycles; collision during that window ignored.
REQ-035 Second collision with invuln=0 -> lives=0, after hold game_over pulse, state 5; click_l -> state 0.
REQ-036 In GAME click_r -> state 3, run=0, invuln counter frozen; click_r -> state 2; collision during PAUSE no effect.
REQ-037 mouse_left held high 20 cycles in START -> exactly one transition; same-cycle collision and click_r in GAME -> DYING.
REQ-038 rst_n pulsed low mid-COUNTDOWN (not on a clk edge) -> outputs at reset values immediately.
